// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer sharing one memory port; all outputs registered.
// Optional BUSY-state abort timer is compiled in with `define MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int unsigned DATAWIDTH_BUS  = 32,
    parameter int unsigned DATAWIDTH_ADDR = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      MEM_ARB_CLOCK_50,
    input  logic                      MEM_ARB_RESET_InHigh,
    input  logic                      MEM_ARB_REQ0,
    input  logic                      MEM_ARB_REQ1,
    input  logic                      MEM_ARB_WE0,
    input  logic                      MEM_ARB_WE1,
    input  logic [DATAWIDTH_ADDR-1:0] MEM_ARB_ADDR0,
    input  logic [DATAWIDTH_ADDR-1:0] MEM_ARB_ADDR1,
    input  logic [DATAWIDTH_BUS-1:0]  MEM_ARB_WDATA0,
    input  logic [DATAWIDTH_BUS-1:0]  MEM_ARB_WDATA1,
    output logic                      MEM_ARB_ACK0,
    output logic                      MEM_ARB_ACK1,
    output logic [DATAWIDTH_BUS-1:0]  MEM_ARB_RDATA,
    output logic                      MEM_ARB_ERR,
    output logic                      MEM_ARB_OWNER,
    output logic                      MEM_ARB_MEM_RD,
    output logic                      MEM_ARB_MEM_WR,
    output logic [DATAWIDTH_ADDR-1:0] MEM_ARB_MEM_ADDR,
    output logic [DATAWIDTH_BUS-1:0]  MEM_ARB_MEM_WDATA,
    input  logic [DATAWIDTH_BUS-1:0]  MEM_ARB_MEM_RDATA,
    input  logic                      MEM_ARB_MEM_READY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    state_t                    state_q, state_d;
    logic                      last_grant_q, last_grant_d;
    logic                      owner_q, owner_d;
    logic                      we_q, we_d;
    logic                      mem_rd_q, mem_rd_d;
    logic                      mem_wr_q, mem_wr_d;
    logic [DATAWIDTH_ADDR-1:0] mem_addr_q, mem_addr_d;
    logic [DATAWIDTH_BUS-1:0]  mem_wdata_q, mem_wdata_d;
    logic [DATAWIDTH_BUS-1:0]  rdata_q, rdata_d;
    logic                      ack0_q, ack0_d;
    logic                      ack1_q, ack1_d;
    logic                      winner;

    // A tie goes to the requester that was not served last; a single request wins outright.
    assign winner = (MEM_ARB_REQ0 && MEM_ARB_REQ1) ? ~last_grant_q : MEM_ARB_REQ1;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timeout;

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        mem_rd_d     = mem_rd_q;
        mem_wr_d     = mem_wr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (MEM_ARB_REQ0 || MEM_ARB_REQ1) begin
                    owner_d      = winner;
                    last_grant_d = winner;
                    we_d         = winner ? MEM_ARB_WE1 : MEM_ARB_WE0;
                    mem_addr_d   = winner ? MEM_ARB_ADDR1 : MEM_ARB_ADDR0;
                    mem_wdata_d  = winner ? MEM_ARB_WDATA1 : MEM_ARB_WDATA0;
                    mem_rd_d     = ~we_d;
                    mem_wr_d     = we_d;
                    state_d      = BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end
            end
            BUSY: begin
                if (MEM_ARB_MEM_READY) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = MEM_ARB_MEM_RDATA;
                    end
                    ack0_d  = ~owner_q;
                    ack1_d  = owner_q;
                    state_d = RESP;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                // READY on the timeout edge takes the branch above, so it wins.
                else if (timeout) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    ack0_d   = ~owner_q;
                    ack1_d   = owner_q;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge MEM_ARB_CLOCK_50 or posedge MEM_ARB_RESET_InHigh) begin
        if (MEM_ARB_RESET_InHigh) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    assign MEM_ARB_ACK0      = ack0_q;
    assign MEM_ARB_ACK1      = ack1_q;
    assign MEM_ARB_RDATA     = rdata_q;
    assign MEM_ARB_OWNER     = owner_q;
    assign MEM_ARB_MEM_RD    = mem_rd_q;
    assign MEM_ARB_MEM_WR    = mem_wr_q;
    assign MEM_ARB_MEM_ADDR  = mem_addr_q;
    assign MEM_ARB_MEM_WDATA = mem_wdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    assign MEM_ARB_ERR       = err_q;
`else
    assign MEM_ARB_ERR       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected grants/acks, a negedge monitor pops and compares.
// Also honours MEM_ARB_TIMEOUT_EN when the design is built with it.
module tb_mem_arbiter;
    localparam int unsigned TO = 16;

    typedef struct {
        bit          owner;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
    } grant_t;

    typedef struct {
        bit          owner;
        logic [31:0] rdata;
        bit          err;
        int          cyc;
    } ack_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, err, owner, mem_rd, mem_wr;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    grant_t exp_g[$];
    ack_t   exp_a[$];
    int     cyc = 0;
    bit     done = 1'b0;
    int     n_cmp = 0;
    int     n_bad = 0;

    bit          m_last  = 1'b1;
    logic [31:0] m_rdata = '0;

    mem_arbiter #(
        .DATAWIDTH_BUS (32),
        .DATAWIDTH_ADDR(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .MEM_ARB_CLOCK_50    (clk),
        .MEM_ARB_RESET_InHigh(rst),
        .MEM_ARB_REQ0        (req0),
        .MEM_ARB_REQ1        (req1),
        .MEM_ARB_WE0         (we0),
        .MEM_ARB_WE1         (we1),
        .MEM_ARB_ADDR0       (addr0),
        .MEM_ARB_ADDR1       (addr1),
        .MEM_ARB_WDATA0      (wdata0),
        .MEM_ARB_WDATA1      (wdata1),
        .MEM_ARB_ACK0        (ack0),
        .MEM_ARB_ACK1        (ack1),
        .MEM_ARB_RDATA       (rdata),
        .MEM_ARB_ERR         (err),
        .MEM_ARB_OWNER       (owner),
        .MEM_ARB_MEM_RD      (mem_rd),
        .MEM_ARB_MEM_WR      (mem_wr),
        .MEM_ARB_MEM_ADDR    (mem_addr),
        .MEM_ARB_MEM_WDATA   (mem_wdata),
        .MEM_ARB_MEM_RDATA   (mem_rdata),
        .MEM_ARB_MEM_READY   (mem_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    bit     prev_strobe = 1'b0;
    grant_t cur_g;

    always @(negedge clk) begin
        if (done) begin
            chk("grant_queue_left", 128'(exp_g.size()), 128'(0));
            chk("ack_queue_left", 128'(exp_a.size()), 128'(0));
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end else if (rst) begin
            chk("reset_outputs", {ack0, ack1, err, owner, mem_rd, mem_wr, rdata, mem_addr, mem_wdata}, 128'(0));
            prev_strobe = 1'b0;
        end else begin
            if ((mem_rd || mem_wr) && !prev_strobe) begin
                if (exp_g.size() == 0) begin
                    chk("spurious_grant", {mem_rd, mem_wr}, 128'(0));
                end else begin
                    cur_g = exp_g.pop_front();
                    chk("grant", {owner, mem_rd, mem_wr, mem_addr, mem_wdata},
                        {cur_g.owner, ~cur_g.we, cur_g.we, cur_g.addr, cur_g.wdata});
                    chk("grant_cycle", 128'(cyc), 128'(cur_g.cyc));
                end
            end else if (mem_rd || mem_wr) begin
                chk("busy_hold", {owner, mem_rd, mem_wr, mem_addr, mem_wdata},
                    {cur_g.owner, ~cur_g.we, cur_g.we, cur_g.addr, cur_g.wdata});
            end
            if (ack0 || ack1) begin
                if (exp_a.size() == 0) begin
                    chk("spurious_ack", {ack0, ack1}, 128'(0));
                end else begin
                    ack_t a;
                    a = exp_a.pop_front();
                    chk("ack", {ack0, ack1, err, rdata}, {~a.owner, a.owner, a.err, a.rdata});
                    chk("ack_cycle", 128'(cyc), 128'(a.cyc));
                end
            end else begin
                chk("err_without_ack", 128'(err), 128'(0));
            end
            prev_strobe = mem_rd || mem_wr;
        end
    end

    // ---------------- stimulus + reference model ----------------
    task automatic junk();
        addr0  = $urandom; addr1  = $urandom;
        wdata0 = $urandom; wdata1 = $urandom;
        we0    = 1'($urandom); we1 = 1'($urandom);
        mem_rdata = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req0 = 1'b0; req1 = 1'b0;
            mem_ready = 1'($urandom);
            junk();
        end
    endtask

    // One request pattern; memory answers after w wait cycles (or a reset aborts it).
    task automatic run_txn(input bit r0, input bit r1, input bit w0, input bit w1,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input int w, input logic [31:0] rd, input bit do_reset);
        int     c, eff;
        bit     win, e;
        grant_t g;
        ack_t   a;
        @(negedge clk);
        c = cyc;
        req0 = r0; req1 = r1; we0 = w0; we1 = w1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        mem_ready = 1'($urandom);
        win    = (r0 && r1) ? !m_last : r1;
        m_last = win;
        g.owner = win;
        g.we    = win ? w1 : w0;
        g.addr  = win ? a1 : a0;
        g.wdata = win ? d1 : d0;
        g.cyc   = c + 1;
        exp_g.push_back(g);
`ifdef MEM_ARB_TIMEOUT_EN
        e   = (w > int'(TO) - 1);
        eff = e ? int'(TO) - 1 : w;
`else
        e   = 1'b0;
        eff = w;
`endif
        @(negedge clk);
        mem_ready = 1'b0;
        if (do_reset) begin
            @(posedge clk);
            #1 rst = 1'b1;
            @(negedge clk);
            #1 rst = 1'b0;
            req0 = 1'b0; req1 = 1'b0;
            m_last  = 1'b1;
            m_rdata = '0;
            return;
        end
        if (!e && !g.we) m_rdata = rd;
        a.owner = win;
        a.rdata = m_rdata;
        a.err   = e;
        a.cyc   = c + 2 + eff;
        exp_a.push_back(a);
        repeat (eff) begin
            junk();
            mem_ready = 1'b0;
            @(negedge clk);
        end
        if (!e) begin
            mem_ready = 1'b1;
            mem_rdata = rd;
        end
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        mem_ready = 1'($urandom);
        mem_rdata = $urandom;
    endtask

    // Requests held continuously with READY tied high: back-to-back 3-cycle transactions.
    task automatic held(input bit r0, input bit r1, input bit w0, input bit w1,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] rd, input int n);
        int     c;
        bit     win;
        grant_t g;
        ack_t   a;
        @(negedge clk);
        c = cyc;
        req0 = r0; req1 = r1; we0 = w0; we1 = w1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        mem_ready = 1'b1;
        mem_rdata = rd;
        for (int k = 0; k < n; k++) begin
            win     = (r0 && r1) ? !m_last : r1;
            m_last  = win;
            g.owner = win;
            g.we    = win ? w1 : w0;
            g.addr  = win ? a1 : a0;
            g.wdata = win ? d1 : d0;
            g.cyc   = c + 1 + 3 * k;
            exp_g.push_back(g);
            if (!g.we) m_rdata = rd;
            a.owner = win;
            a.rdata = m_rdata;
            a.err   = 1'b0;
            a.cyc   = c + 2 + 3 * k;
            exp_a.push_back(a);
        end
        repeat (3 * n - 1) @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        mem_ready = 1'b0;
    endtask

    initial begin
        bit [1:0] p;
        int       w;
        // Reset held while a request and READY are both active.
        req0 = 1'b1; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        req0 = 1'b0; mem_ready = 1'b0;

        run_txn(1, 1, 0, 0, 32'h200, 32'h300, 0, 0, 1, 32'h1234_5678, 0);
        run_txn(1, 0, 0, 0, 32'h100, 32'h0, 0, 0, 2, 32'hDEAD_BEEF, 0);
        run_txn(0, 1, 0, 1, 32'h0, 32'h44, 0, 32'hA5A5, 0, 32'h0, 0);
        held(1, 1, 1, 0, 32'h10, 32'h20, 32'h55, 32'h0, 32'hCAFE_F00D, 4);
        run_txn(0, 1, 0, 1, 32'h0, 32'h80, 0, 32'h77, 5, 32'h0, 1);
        run_txn(1, 1, 0, 1, 32'h90, 32'h94, 0, 32'h1, 0, 32'h0BAD_CAFE, 0);
        held(1, 0, 0, 0, 32'h400, 32'h0, 0, 0, 32'h600D_0001, 3);
        idle(6);
        run_txn(1, 0, 0, 0, 32'h500, 32'h0, 0, 0, 100, 32'h1357_9BDF, 0);
        run_txn(0, 1, 0, 0, 32'h0, 32'h504, 0, 0, 15, 32'h2468_ACE0, 0);

        for (int i = 0; i < 40; i++) begin
            p = 2'($urandom_range(1, 3));
            w = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(13, 17));
            run_txn(p[0], p[1], 1'($urandom), 1'($urandom), $urandom, $urandom,
                    $urandom, $urandom, w, $urandom, 0);
            idle(int'($urandom_range(0, 2)));
        end

        idle(2);
        done = 1'b1;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter and sequencer for main memory. It shares one memory port between requester 0 (Centro_Control microword RD/WR strobes) and requester 1 (instruction-fetch / IO port). It latches each request, drives the memory strobes, waits for memory ready and returns the ACK that the control unit's CSAI uses to advance. Ties are resolved round-robin.

Parameters:
DATAWIDTH_BUS, 32, data width of read/write data
DATAWIDTH_ADDR, 32, address width
TIMEOUT_CYCLES, 16, BUSY cycles before abort (used only with MEM_ARB_TIMEOUT_EN)

Ports:
MEM_ARB_CLOCK_50  input  1  single clock, rising edge
MEM_ARB_RESET_InHigh  input  1  asynchronous reset, active-high
MEM_ARB_REQ0 / MEM_ARB_REQ1  input  1  level request, held until ACK
MEM_ARB_WE0 / MEM_ARB_WE1  input  1  1 = write, 0 = read
MEM_ARB_ADDR0 / MEM_ARB_ADDR1  input  DATAWIDTH_ADDR  request address
MEM_ARB_WDATA0 / MEM_ARB_WDATA1  input  DATAWIDTH_BUS  write data
MEM_ARB_ACK0 / MEM_ARB_ACK1  output  1  one-cycle completion pulse
MEM_ARB_RDATA  output  DATAWIDTH_BUS  shared read data, valid while ACKx is high
MEM_ARB_ERR  output  1  transaction aborted, valid with ACKx
MEM_ARB_OWNER  output  1  index of the current or last granted requester
MEM_ARB_MEM_RD / MEM_ARB_MEM_WR  output  1  memory strobes
MEM_ARB_MEM_ADDR  output  DATAWIDTH_ADDR  memory address
MEM_ARB_MEM_WDATA  output  DATAWIDTH_BUS  memory write data
MEM_ARB_MEM_RDATA  input  DATAWIDTH_BUS  memory read data
MEM_ARB_MEM_READY  input  1  memory completion, sampled at rising edge

Behaviour:
- Clock and reset: one clock, MEM_ARB_CLOCK_50. Reset MEM_ARB_RESET_InHigh is asynchronous and active-high.
- Reset values: state=IDLE, last_grant=1, every output 0 (strobes, ACKs, ERR, OWNER, RDATA, MEM_ADDR, MEM_WDATA).
- State machine: IDLE, BUSY, RESP. All outputs are registered.
- IDLE, no REQ high: stay in IDLE.
- IDLE, exactly one REQ high at the edge: grant it.
- IDLE, both REQ high: grant ~last_grant, so requester 0 wins the first tie after reset.
- On grant:
  - latch WE, ADDR and WDATA of the winner;
  - set OWNER and last_grant to the winner;
  - assert MEM_RD (WE=0) or MEM_WR (WE=1);
  - go to BUSY.
- BUSY: strobes, MEM_ADDR and MEM_WDATA held constant. Changes on REQ, WE, ADDR or WDATA are ignored.
- BUSY, MEM_READY high at the edge:
  - drop the strobes;
  - for a read, capture MEM_RDATA into RDATA; for a write, RDATA keeps its previous value;
  - assert ACK[OWNER];
  - go to RESP.
- RESP: ACK high for exactly one cycle, REQs ignored, then IDLE.
- Requesters must drop or renew REQ by the edge at which they sample ACK high. A REQ still high in IDLE starts a new transaction.
- Latency: REQ sampled at edge t0 gives a strobe high after t0. READY sampled at edge t1 gives ACK high after t1. Minimum is 2 edges request-to-ACK and 3 cycles per transaction.
- MEM_READY is ignored in IDLE and RESP.
- ACK0 and ACK1 are never high together.
- Reset asserted mid-BUSY or mid-RESP: strobes and ACK drop immediately with no ACK issued, and last_grant returns to 1.
- ERR is 0 unless the timeout feature aborts a transaction.

Optional Feature:
Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - a counter clears on entry to BUSY and increments on each BUSY cycle without READY;
  - when it reaches TIMEOUT_CYCLES, strobes drop, ACK[OWNER] and ERR pulse together for one cycle in RESP, and RDATA is unchanged;
  - READY arriving on the same edge as the timeout wins (normal completion, ERR=0).
- Undefined: no counter. BUSY waits indefinitely and ERR is tied 0.

Test Plan:
1. Reset asserted while REQ0=1 and MEM_READY=1 -> every output 0; after release, the first tie grants requester 0.
2. REQ0 read, ADDR0=0x100, READY after 2 wait cycles with MEM_RDATA=0xDEADBEEF -> MEM_RD high 3 cycles with MEM_ADDR=0x100; ACK0 one cycle with RDATA=0xDEADBEEF; ACK1=0.
3. REQ0 (write 0x55 to 0x10) and REQ1 (read 0x20) held continuously with READY tied 1 -> grant order 0,1,0,1; ACKs alternate every 3 cycles; OWNER matches; RDATA unchanged on write ACKs.
4. REQ1 write, reset pulsed during the 2nd BUSY cycle -> MEM_WR falls asynchronously; no ACK1; next simultaneous request grants 0.
5. With MEM_ARB_TIMEOUT_EN and READY never high -> ACK0 and ERR high 1 cycle after 16 BUSY cycles. Without the macro, MEM_RD stays high for 100 cycles and ERR stays 0.
6. READY tied 1, REQ0 read held for 3 transactions -> ACK0 at cycles 2, 5 and 8; MEM_READY toggled in IDLE causes no ACK.
